// File: rtl/cpld_tap_shifter_pkg.sv
// Shared types for the tap shifter: operating modes, fill-tracker states
// and a constant-foldable clog2.
package cpld_pkg;

    typedef enum logic [1:0] {
        MODE_HOLD   = 2'b00,
        MODE_SHIFT  = 2'b01,
        MODE_ROTATE = 2'b10,
        MODE_CLEAR  = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        EMPTY,
        FILLING,
        FULL
    } fill_state_e;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        int unsigned v;
        r = 0;
        v = 1;
        while (v < value) begin
            v = v << 1;
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/cpld_tap_shifter_if.sv
// Data/control bundle of the tap shifter; master drives mode/data/select,
// slave (the shifter) returns the tap, tail and fill status.
interface cpld_tap_shifter_if
    import cpld_pkg::*;
#(
    parameter int unsigned WIDTH = 5,
    parameter int unsigned DEPTH = 8
);
    localparam int unsigned SEL_W = (clog2(DEPTH) > 1) ? clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = clog2(DEPTH + 1);

    logic [1:0]       mode;
    logic [WIDTH-1:0] left_in;
    logic [DEPTH-1:0] sel;
    logic [SEL_W-1:0] sel_out;
    logic             sel_valid;
    logic [DEPTH-1:0] sel_decoded;
    logic [WIDTH-1:0] tap_out;
    logic [WIDTH-1:0] right_out;
    logic [CNT_W-1:0] fill_count;
    logic             full;

    modport master (
        output mode, left_in, sel,
        input  sel_out, sel_valid, sel_decoded, tap_out, right_out, fill_count, full
    );

    modport slave (
        input  mode, left_in, sel,
        output sel_out, sel_valid, sel_decoded, tap_out, right_out, fill_count, full
    );

endinterface

// File: rtl/cpld_tap_shifter_prio_enc.sv
// Combinational lowest-index-wins priority encoder for the tap request vector.
module cpld_prio_enc #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned SEL_W = 3
) (
    input  logic [DEPTH-1:0] req_i,
    output logic [SEL_W-1:0] idx_o,
    output logic             valid_o
);

    logic found;

    always_comb begin
        idx_o = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (req_i[i] && !found) begin
                idx_o = SEL_W'(i);
                found = 1'b1;
            end
        end
        valid_o = found;
    end

endmodule

// File: rtl/cpld_tap_shifter.sv
// DEPTH x WIDTH shift chain with hold/shift/rotate/clear, a registered
// priority-encoded tap select and a saturating fill tracker.
module cpld_tap_shifter
    import cpld_pkg::*;
#(
    parameter int unsigned WIDTH = 5,
    parameter int unsigned DEPTH = 8
) (
    input  logic                clk,
    input  logic                rst,
    cpld_tap_shifter_if.slave   bus
);

    localparam int unsigned SEL_W = (clog2(DEPTH) > 1) ? clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = clog2(DEPTH + 1);

    logic [WIDTH-1:0] stage_q [DEPTH];
    logic [WIDTH-1:0] stage_d [DEPTH];
    fill_state_e      state_q;
    logic [CNT_W-1:0] count_q;
    logic [SEL_W-1:0] sel_out_q;
    logic             sel_valid_q;
    logic [DEPTH-1:0] sel_dec_q;
    logic [DEPTH-1:0] sel_dec_d;
    logic [SEL_W-1:0] enc_idx;
    logic             enc_valid;
    mode_e            mode;

    assign mode = mode_e'(bus.mode);

    cpld_prio_enc #(
        .DEPTH (DEPTH),
        .SEL_W (SEL_W)
    ) u_prio_enc (
        .req_i   (bus.sel),
        .idx_o   (enc_idx),
        .valid_o (enc_valid)
    );

    assign sel_dec_d = enc_valid ? ({{(DEPTH-1){1'b0}}, 1'b1} << enc_idx) : '0;

    always_comb begin
        stage_d = stage_q;
        case (mode)
            MODE_SHIFT: begin
                stage_d[0] = bus.left_in;
                for (int unsigned i = 1; i < DEPTH; i++) stage_d[i] = stage_q[i-1];
            end
            MODE_ROTATE: begin
                stage_d[0] = stage_q[DEPTH-1];
                for (int unsigned i = 1; i < DEPTH; i++) stage_d[i] = stage_q[i-1];
            end
            MODE_CLEAR: begin
                for (int unsigned i = 0; i < DEPTH; i++) stage_d[i] = '0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) stage_q[i] <= '0;
            state_q     <= EMPTY;
            count_q     <= '0;
            sel_out_q   <= '0;
            sel_valid_q <= 1'b0;
            sel_dec_q   <= '0;
        end else begin
            stage_q     <= stage_d;
            sel_out_q   <= enc_idx;
            sel_valid_q <= enc_valid;
            sel_dec_q   <= sel_dec_d;
            // Count saturates in FULL; hold and rotate leave the tracker alone.
            case (mode)
                MODE_SHIFT: begin
                    case (state_q)
                        EMPTY: begin
                            count_q <= CNT_W'(1);
                            state_q <= FILLING;
                        end
                        FILLING: begin
                            count_q <= count_q + CNT_W'(1);
                            if (count_q == CNT_W'(DEPTH - 1)) state_q <= FULL;
                        end
                        default: ;
                    endcase
                end
                MODE_CLEAR: begin
                    count_q <= '0;
                    state_q <= EMPTY;
                end
                default: ;
            endcase
        end
    end

    assign bus.sel_out     = sel_out_q;
    assign bus.sel_valid   = sel_valid_q;
    assign bus.sel_decoded = sel_dec_q;
    assign bus.tap_out     = sel_valid_q ? stage_q[sel_out_q] : '0;
    assign bus.right_out   = stage_q[DEPTH-1];
    assign bus.fill_count  = count_q;
    assign bus.full        = (state_q == FULL);

endmodule
